// File: rtl/draw_field_snapshot_ctrl.sv
// Frame-synchronous field snapshot scheduler.
// When game logic requests it, the controller waits for the next rising edge of vblank. It then
// copies the playfield row by row into a shadow register and latches the next-block preview.
// The renderer only reads the shadow copy, so no frame shows a half-updated field.
module draw_field_snapshot_ctrl #(
   parameter int unsigned PIX_WIDTH = 12,
   parameter int unsigned ROW_CNT   = 20,
   parameter int unsigned COL_CNT   = 10,
   parameter int unsigned COLOR_W   = 3,
   parameter int unsigned V_ACTIVE  = 1024,
   parameter int unsigned ROW_W     = $clog2(ROW_CNT)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_n_i,
   input  logic [PIX_WIDTH-1:0]                 pix_y_i,
   input  logic                                 upd_req_i,
   output logic                                 upd_ack_o,
   output logic [ROW_W-1:0]                     rd_row_o,
   output logic                                 rd_en_o,
   input  logic [COL_CNT*COLOR_W-1:0]           rd_data_i,
   input  logic [63:0]                          nb_data_i,
   input  logic [COLOR_W-1:0]                   nb_color_i,
   input  logic [1:0]                           nb_rot_i,
   input  logic                                 nb_draw_en_i,
   output logic [ROW_CNT*COL_CNT*COLOR_W-1:0]   field_o,
   output logic [63:0]                          nb_data_o,
   output logic [COLOR_W-1:0]                   nb_color_o,
   output logic [1:0]                           nb_rot_o,
   output logic                                 nb_draw_en_o,
   output logic                                 busy_o,
   output logic [7:0]                           frame_cnt_o
);

   localparam int unsigned RW    = COL_CNT * COLOR_W;
   localparam int unsigned CNT_W = $clog2(ROW_CNT + 1);

   typedef enum logic [1:0] {StIdle, StWaitVbl, StCopy, StAck} state_e;

   state_e           state_q;
   logic             vbl;
   logic             vbl_q;
   logic             vbl_rise;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic [ROW_W-1:0] wr_row;
   logic [RW-1:0]    shadow_q [ROW_CNT];

   assign vbl      = (pix_y_i >= PIX_WIDTH'(V_ACTIVE));
   assign vbl_rise = vbl & ~vbl_q;
   assign cnt_nxt  = cnt_q + CNT_W'(1);
   // Read data arriving in copy cycle c belongs to the row requested in cycle c-1.
   assign wr_row   = ROW_W'(cnt_q - CNT_W'(1));

   // Flatten the shadow rows onto the renderer bus, row r at bits [r*RW +: RW].
   always_comb begin
      field_o = '0;
      for (int r = 0; r < int'(ROW_CNT); r++) begin
         field_o[r*RW +: RW] = shadow_q[r];
      end
   end

   // Snapshot FSM with registered outputs, vblank edge detector and frame counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= StIdle;
         vbl_q        <= 1'b1;  // no false edge when reset releases inside vblank
         frame_cnt_o  <= '0;
         cnt_q        <= '0;
         upd_ack_o    <= 1'b0;
         rd_en_o      <= 1'b0;
         rd_row_o     <= '0;
         busy_o       <= 1'b0;
         nb_data_o    <= '0;
         nb_color_o   <= '0;
         nb_rot_o     <= '0;
         nb_draw_en_o <= 1'b0;
         for (int r = 0; r < int'(ROW_CNT); r++) begin
            shadow_q[r] <= '0;
         end
      end else begin
         vbl_q     <= vbl;
         upd_ack_o <= 1'b0;
         if (vbl_rise) begin
            frame_cnt_o <= frame_cnt_o + 8'd1;
         end
         unique case (state_q)
            StIdle: begin
               // An edge coinciding with the request is deliberately skipped.
               if (upd_req_i) begin
                  state_q <= StWaitVbl;
                  busy_o  <= 1'b1;
               end
            end
            StWaitVbl: begin
               if (!upd_req_i) begin
                  state_q <= StIdle;
                  busy_o  <= 1'b0;
               end else if (vbl_rise) begin
                  state_q      <= StCopy;
                  cnt_q        <= '0;
                  rd_en_o      <= 1'b1;
                  rd_row_o     <= '0;
                  nb_data_o    <= nb_data_i;
                  nb_color_o   <= nb_color_i;
                  nb_rot_o     <= nb_rot_i;
                  nb_draw_en_o <= nb_draw_en_i;
               end
            end
            StCopy: begin
               // Once started, the copy always runs to completion.
               if (cnt_q != '0) begin
                  shadow_q[wr_row] <= rd_data_i;
               end
               if (cnt_q == CNT_W'(ROW_CNT)) begin
                  state_q   <= StAck;
                  upd_ack_o <= 1'b1;
               end else begin
                  cnt_q <= cnt_nxt;
                  if (cnt_nxt < CNT_W'(ROW_CNT)) begin
                     rd_en_o  <= 1'b1;
                     rd_row_o <= ROW_W'(cnt_nxt);
                  end else begin
                     rd_en_o  <= 1'b0;
                  end
               end
            end
            StAck: begin
               state_q <= StIdle;
               busy_o  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_draw_field_snapshot_ctrl.sv
// Directed bench for draw_field_snapshot_ctrl: reset inside vblank, full snapshot timing,
// preview latching, request withdrawal, back-to-back requests, frame counter wrap and
// a reset issued in the middle of a copy.
module tb_draw_field_snapshot_ctrl;

   localparam int unsigned PW = 12;
   localparam int unsigned RC = 20;
   localparam int unsigned CC = 10;
   localparam int unsigned CW = 3;
   localparam int unsigned RW = CC * CW;
   localparam int unsigned FW = RC * RW;

   logic          clk;
   logic          rst_n;
   logic [PW-1:0] pix_y;
   logic          upd_req;
   logic          upd_ack;
   logic [4:0]    rd_row;
   logic          rd_en;
   logic [RW-1:0] rd_data;
   logic [63:0]   nb_data_in;
   logic [CW-1:0] nb_color_in;
   logic [1:0]    nb_rot_in;
   logic          nb_draw_en_in;
   logic [FW-1:0] field;
   logic [63:0]   nb_data_out;
   logic [CW-1:0] nb_color_out;
   logic [1:0]    nb_rot_out;
   logic          nb_draw_en_out;
   logic          busy;
   logic [7:0]    frame_cnt;

   logic [RW-1:0] ram [RC];
   int            total = 0;
   int            bad   = 0;
   logic          seen;

   draw_field_snapshot_ctrl dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .pix_y_i      (pix_y),
      .upd_req_i    (upd_req),
      .upd_ack_o    (upd_ack),
      .rd_row_o     (rd_row),
      .rd_en_o      (rd_en),
      .rd_data_i    (rd_data),
      .nb_data_i    (nb_data_in),
      .nb_color_i   (nb_color_in),
      .nb_rot_i     (nb_rot_in),
      .nb_draw_en_i (nb_draw_en_in),
      .field_o      (field),
      .nb_data_o    (nb_data_out),
      .nb_color_o   (nb_color_out),
      .nb_rot_o     (nb_rot_out),
      .nb_draw_en_o (nb_draw_en_out),
      .busy_o       (busy),
      .frame_cnt_o  (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Field RAM model: data valid one cycle after the read strobe.
   always @(posedge clk) begin
      if (rd_en) rd_data <= ram[rd_row];
   end

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // pat 0: row r = {CC{r[2:0]}}, pat 1: row r = {CC{~r[2:0]}}
   function automatic logic [RW-1:0] row_val(input int pat, input int r);
      logic [2:0] v;
      v = r[2:0];
      if (pat != 0) v = ~v;
      return {CC{v}};
   endfunction

   function automatic logic [FW-1:0] exp_field(input int pat);
      logic [FW-1:0] f;
      f = '0;
      for (int r = 0; r < int'(RC); r++) f[r*RW +: RW] = row_val(pat, r);
      return f;
   endfunction

   task automatic load_ram(input int pat);
      for (int r = 0; r < int'(RC); r++) ram[r] = row_val(pat, r);
   endtask

   initial begin
      rst_n = 1'b0;  pix_y = 12'd1030;  upd_req = 1'b0;  rd_data = '0;
      nb_data_in = '0;  nb_color_in = '0;  nb_rot_in = '0;  nb_draw_en_in = 1'b0;
      load_ram(0);

      // Reset state
      cyc(3);
      chk("rst_field", field, '0);
      chk("rst_busy", busy, 0);
      chk("rst_ack", upd_ack, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_row", rd_row, 0);
      chk("rst_frame", frame_cnt, 0);
      chk("rst_nb", {nb_data_out, nb_color_out, nb_rot_out, nb_draw_en_out}, '0);

      // Release inside vblank with request pending: no copy without a fresh edge
      rst_n = 1'b1;  upd_req = 1'b1;
      cyc(1);
      chk("wait_busy", busy, 1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         if (rd_en) seen = 1'b1;
      end
      chk("no_false_edge", seen, 0);
      chk("no_false_frame", frame_cnt, 0);

      // First snapshot
      nb_data_in = 64'h0123_4567_89ab_cdef;  nb_color_in = 3'd5;  nb_rot_in = 2'd2;
      nb_draw_en_in = 1'b1;
      pix_y = 12'd100;
      cyc(3);
      pix_y = 12'd1024;
      for (int c = 0; c < int'(RC); c++) begin
         cyc(1);
         chk($sformatf("copy_en_%0d", c), rd_en, 1);
         chk($sformatf("copy_row_%0d", c), rd_row, c);
         chk($sformatf("copy_noack_%0d", c), upd_ack, 0);
         if (c == 0) begin
            chk("frame_1", frame_cnt, 1);
            chk("copy_busy", busy, 1);
         end
         if (c == 3) begin
            nb_color_in = 3'd1;  nb_rot_in = 2'd0;  nb_data_in = '0;  nb_draw_en_in = 1'b0;
         end
      end
      cyc(1);
      chk("last_en", rd_en, 0);
      chk("last_row_hold", rd_row, 19);
      chk("ack_early", upd_ack, 0);
      cyc(1);
      chk("ack_22", upd_ack, 1);
      chk("nb_color", nb_color_out, 5);
      chk("nb_rot", nb_rot_out, 2);
      chk("nb_data", nb_data_out, 64'h0123_4567_89ab_cdef);
      chk("nb_draw_en", nb_draw_en_out, 1);
      chk("row7", field[7*RW +: RW], 30'o7777777777);
      chk("field_pat0", field, exp_field(0));
      upd_req = 1'b0;
      cyc(1);
      chk("ack_one_cycle", upd_ack, 0);
      chk("idle_busy", busy, 0);

      // Request withdrawn before vblank: nothing copied
      load_ram(1);
      pix_y = 12'd100;  upd_req = 1'b1;
      cyc(3);
      chk("wd_busy", busy, 1);
      upd_req = 1'b0;
      cyc(1);
      chk("wd_idle", busy, 0);
      pix_y = 12'd1030;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         cyc(1);
         if (rd_en || upd_ack) seen = 1'b1;
      end
      chk("wd_no_copy", seen, 0);
      chk("wd_field", field, exp_field(0));
      chk("frame_2", frame_cnt, 2);

      // Request held through ack: second copy waits for the next edge
      pix_y = 12'd100;  upd_req = 1'b1;
      cyc(3);
      pix_y = 12'd1024;
      cyc(21);
      chk("hold_ack_early", upd_ack, 0);
      cyc(1);
      chk("hold_ack", upd_ack, 1);
      chk("field_pat1", field, exp_field(1));
      cyc(1);
      chk("hold_idle", busy, 0);
      cyc(1);
      chk("hold_rewait", busy, 1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (rd_en) seen = 1'b1;
      end
      chk("hold_no_immediate", seen, 0);
      pix_y = 12'd100;
      cyc(2);
      pix_y = 12'd1024;
      cyc(1);
      chk("second_en", rd_en, 1);
      chk("second_row", rd_row, 0);
      cyc(21);
      chk("second_ack", upd_ack, 1);
      upd_req = 1'b0;
      chk("frame_4", frame_cnt, 4);

      // Frame counter wrap
      for (int i = 0; i < 251; i++) begin
         pix_y = 12'd100;
         cyc(1);
         pix_y = 12'd1024;
         cyc(1);
      end
      chk("frame_255", frame_cnt, 255);
      pix_y = 12'd100;
      cyc(1);
      pix_y = 12'd1024;
      cyc(1);
      chk("frame_wrap", frame_cnt, 0);

      // Reset in the middle of a copy
      pix_y = 12'd100;  upd_req = 1'b1;
      cyc(2);
      pix_y = 12'd1024;
      cyc(11);
      chk("mid_row10", rd_row, 10);
      chk("mid_field_nz", (field != '0), 1);
      upd_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_field_clr", field, '0);
      chk("mid_busy_clr", busy, 0);
      chk("mid_en_clr", rd_en, 0);
      cyc(2);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         if (upd_ack || rd_en) seen = 1'b1;
      end
      chk("mid_no_ack", seen, 0);
      chk("mid_frame", frame_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/draw_field_snapshot_ctrl.md
Name: draw_field_snapshot_ctrl

Overview:
- Frame-synchronous snapshot scheduler that sits between the game-logic core and the field renderer.
- On request from game logic, it waits for the start of vertical blanking, then copies the playfield row by row from the game-logic field RAM into a shadow register.
- In the same window it latches the next-block preview data.
- The renderer only ever reads the shadow copy, so no frame shows a half-updated field (no tearing).

Parameters:
- PIX_WIDTH, 12, width of pixel coordinates.
- ROW_CNT, 20, playfield rows.
- COL_CNT, 10, playfield columns.
- COLOR_W, 3, bits per brick colour index.
- V_ACTIVE, 1024, first non-visible line; pix_y_i >= V_ACTIVE means vblank.
- ROW_W, $clog2(ROW_CNT), row address width.

Ports:
- clk_i  in  1  pixel clock.
- rst_n_i  in  1  asynchronous active-low reset.
- pix_y_i  in  PIX_WIDTH  current raster line from the VGA timing generator.
- upd_req_i  in  1  level request from game logic: new field/next-block data ready; held until ack.
- upd_ack_o  out  1  one-cycle pulse: snapshot complete.
- rd_row_o  out  ROW_W  field RAM row address.
- rd_en_o  out  1  field RAM read strobe.
- rd_data_i  in  COL_CNT*COLOR_W  row data; valid exactly one cycle after rd_en_o.
- nb_data_i  in  64  next-block data, [rot][row][col].
- nb_color_i  in  COLOR_W  next-block colour.
- nb_rot_i  in  2  next-block rotation.
- nb_draw_en_i  in  1  next-block preview enable.
- field_o  out  ROW_CNT*COL_CNT*COLOR_W  shadow field; row r occupies bits [r*COL_CNT*COLOR_W +: COL_CNT*COLOR_W].
- nb_data_o, nb_color_o, nb_rot_o, nb_draw_en_o  out  same widths as inputs  latched preview data.
- busy_o  out  1  high in WAIT_VBL, COPY or ACK.
- frame_cnt_o  out  8  counts vblank rising edges; wraps 255 -> 0.

Behaviour:
- Reset (async assert, sync release): state IDLE. field_o, all nb_*_o, upd_ack_o, rd_en_o, rd_row_o, busy_o, frame_cnt_o = 0. vbl_q = 1, so a reset released inside vblank does not produce a false edge.
- vbl = (pix_y_i >= V_ACTIVE); vbl_q is vbl registered.
- vbl_rise = vbl & ~vbl_q. frame_cnt_o increments on every vbl_rise, in every state.
- States:
  - IDLE: if upd_req_i -> WAIT_VBL. The edge is never taken from IDLE, even if upd_req_i rises in the same cycle as vbl_rise; that frame is skipped and the copy waits for the next vbl_rise.
  - WAIT_VBL: if !upd_req_i -> IDLE (request withdrawn, nothing copied). Else on vbl_rise -> COPY with row counter k = 0.
  - COPY: cycle c (c = 0..ROW_CNT-1) drives rd_en_o = 1, rd_row_o = c. Cycle c+1 writes rd_data_i into shadow row c. At COPY entry nb_*_o are latched from nb_*_i in one cycle. COPY lasts ROW_CNT+1 cycles; rd_en_o = 0 in the last one. Then -> ACK.
  - ACK: upd_ack_o = 1 for exactly one cycle -> IDLE. Game logic drops upd_req_i on ack; if it is still high the next cycle, a new WAIT_VBL cycle begins.
- Once COPY starts it always completes, even if upd_req_i drops or vblank ends. ROW_CNT+1 is far below vblank length, so this is a non-issue for legal timing.
- Shadow rows not yet rewritten keep their previous values. field_o changes only during COPY.
- Latency from vbl_rise to upd_ack_o: ROW_CNT+2 cycles (22 with defaults).
- rd_row_o holds its last value when rd_en_o = 0.
- Mid-operation reset: abandon immediately. Shadow is cleared and no ack is issued.

Test Plan:
- Reset with pix_y_i = 1030 (inside vblank), then release with upd_req_i = 1 -> no copy until pix_y goes <1024 then >=1024. First rd_en_o occurs the cycle after that rise.
- RAM preloaded with row r = {COL_CNT{r[2:0]}}, request, vblank -> rd_row_o sequences 0..19 on consecutive cycles. field_o row 7 = 30'o7777777777. upd_ack_o pulses exactly 22 cycles after vbl_rise.
- nb_color_i = 5, nb_rot_i = 2 at COPY entry, changed to 1/0 during COPY -> outputs stay 5/2.
- upd_req_i asserted, then dropped before vblank -> state returns to IDLE, no rd_en_o, no ack, field_o unchanged.
- upd_req_i held high through ack -> second snapshot starts on the following vbl_rise, not immediately. frame_cnt_o increments by 1 per frame, and wraps from 255 to 0.
- rst_n_i pulsed low at COPY row 10 -> field_o = 0 and busy_o = 0 asynchronously. No upd_ack_o afterwards.
